// File: rtl/uart_pkg.sv
// Shared definitions for the UART <-> ALU glue logic: frame-assembly state
// encodings, default data widths and the opcode values the ALU decodes.
package uart_pkg;

  localparam int DEF_NB_DATA = 8;
  localparam int DEF_NB_OP   = 6;
  localparam int NB_STATE    = 3;

  // Frame assembly / result hand-off states. The numeric values are fixed so
  // that a state dump can be read against the TP2 documentation directly.
  typedef enum logic [NB_STATE-1:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // Opcodes understood by the ALU (MIPS-style function codes). The interface
  // block only forwards the low DEF_NB_OP bits of the opcode byte; the ALU
  // itself decodes these values.
  localparam logic [DEF_NB_OP-1:0] OP_ADD = 6'h20;
  localparam logic [DEF_NB_OP-1:0] OP_SUB = 6'h22;
  localparam logic [DEF_NB_OP-1:0] OP_AND = 6'h24;
  localparam logic [DEF_NB_OP-1:0] OP_OR  = 6'h25;
  localparam logic [DEF_NB_OP-1:0] OP_XOR = 6'h26;
  localparam logic [DEF_NB_OP-1:0] OP_SRA = 6'h03;
  localparam logic [DEF_NB_OP-1:0] OP_SRL = 6'h02;
  localparam logic [DEF_NB_OP-1:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Bundle of the receiver, ALU and transmitter signals seen by the
// UART/ALU glue block. The slave modport is the glue block's view; the
// master modport is the surrounding system (rx_uart, ALU, tx_uart).
interface uart_alu_interface_if
  import uart_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int NB_OP   = DEF_NB_OP
) ();

  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] i_rx_data;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done_tick;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_timeout;
  logic               o_overrun;

  modport slave (
    input  i_rx_done_tick,
    input  i_rx_data,
    input  i_alu_result,
    input  i_tx_done_tick,
    output o_alu_a,
    output o_alu_b,
    output o_alu_op,
    output o_tx_data,
    output o_tx_start,
    output o_busy,
    output o_timeout,
    output o_overrun
  );

  modport master (
    output i_rx_done_tick,
    output i_rx_data,
    output i_alu_result,
    output i_tx_done_tick,
    input  o_alu_a,
    input  o_alu_b,
    input  o_alu_op,
    input  o_tx_data,
    input  o_tx_start,
    input  o_busy,
    input  o_timeout,
    input  o_overrun
  );

endinterface

// File: rtl/edge_pulse.sv
// Rising-edge detector: turns a level that may stay high for several clocks
// into a single-cycle pulse on its first high cycle.
module edge_pulse (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_pulse
);

  logic level_q;

  // Remember last cycle's level so a held-high input fires only once
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_level;
    end
  end

  assign o_pulse = i_level & ~level_q;

endmodule

// File: rtl/uart_alu_interface.sv
// Glue between rx_uart, the combinational ALU and tx_uart. Collects three
// received bytes (operand A, operand B, opcode), lets the ALU evaluate the
// registered operands for one cycle, then hands the result byte to the
// transmitter and waits for it to finish. Partial frames are abandoned after
// a configurable idle time; bytes arriving while a result is in flight are
// dropped and flagged.
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int NB_DATA        = DEF_NB_DATA,
  parameter int NB_OP          = DEF_NB_OP,
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                 i_clock,
  input logic                 i_reset,
  uart_alu_interface_if.slave bus
);

  // Last idle count of a partial frame; reaching it without a new byte
  // abandons the frame.
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [NB_TIMEOUT-1:0] CNT_ONE      = NB_TIMEOUT'(1);

  state_t              state_q,      state_d;
  logic [NB_TIMEOUT-1:0] timeoutCnt_q, timeoutCnt_d;
  logic [NB_DATA-1:0]  aluA_q,       aluA_d;
  logic [NB_DATA-1:0]  aluB_q,       aluB_d;
  logic [NB_OP-1:0]    aluOp_q,      aluOp_d;
  logic [NB_DATA-1:0]  txData_q,     txData_d;
  logic                txStart_q,    txStart_d;
  logic                busy_q,       busy_d;
  logic                timeout_q,    timeout_d;
  logic                overrun_q,    overrun_d;

  logic                  byteEvent;
  logic                  cntExpired;
  logic [NB_TIMEOUT-1:0] cntNext;

  edge_pulse u_rx_edge (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (bus.i_rx_done_tick),
    .o_pulse (byteEvent)
  );

  // The counter saturates so a very long idle period can never wrap it back
  // below the abort threshold.
  assign cntExpired = (timeoutCnt_q >= TIMEOUT_LAST);
  assign cntNext    = (timeoutCnt_q == {NB_TIMEOUT{1'b1}}) ? timeoutCnt_q
                                                           : timeoutCnt_q + CNT_ONE;

  // State and datapath registers; everything clears on reset
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= WAIT_A;
      timeoutCnt_q <= '0;
      aluA_q       <= '0;
      aluB_q       <= '0;
      aluOp_q      <= '0;
      txData_q     <= '0;
      txStart_q    <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timeoutCnt_q <= timeoutCnt_d;
      aluA_q       <= aluA_d;
      aluB_q       <= aluB_d;
      aluOp_q      <= aluOp_d;
      txData_q     <= txData_d;
      txStart_q    <= txStart_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: frame assembly, idle abort, result hand-off and overrun
  always_comb begin
    state_d      = state_q;
    timeoutCnt_d = timeoutCnt_q;
    aluA_d       = aluA_q;
    aluB_d       = aluB_q;
    aluOp_d      = aluOp_q;
    txData_d     = txData_q;
    busy_d       = busy_q;
    txStart_d    = 1'b0;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      WAIT_A: begin
        timeoutCnt_d = '0;
        if (byteEvent) begin
          aluA_d  = bus.i_rx_data;
          state_d = WAIT_B;
        end
      end

      WAIT_B: begin
        // A byte arriving on the very last idle cycle still wins over abort
        if (byteEvent) begin
          aluB_d       = bus.i_rx_data;
          timeoutCnt_d = '0;
          state_d      = WAIT_OP;
        end else if (cntExpired) begin
          timeout_d    = 1'b1;
          timeoutCnt_d = '0;
          state_d      = WAIT_A;
        end else begin
          timeoutCnt_d = cntNext;
        end
      end

      WAIT_OP: begin
        if (byteEvent) begin
          aluOp_d      = bus.i_rx_data[NB_OP-1:0];
          busy_d       = 1'b1;
          timeoutCnt_d = '0;
          state_d      = EXEC;
        end else if (cntExpired) begin
          timeout_d    = 1'b1;
          timeoutCnt_d = '0;
          state_d      = WAIT_A;
        end else begin
          timeoutCnt_d = cntNext;
        end
      end

      EXEC: begin
        // Operands have been stable for a full cycle, so the ALU output is
        // settled by the end of it; raising start here makes it visible in
        // SEND.
        timeoutCnt_d = '0;
        txData_d     = bus.i_alu_result;
        txStart_d    = 1'b1;
        overrun_d    = byteEvent;
        state_d      = SEND;
      end

      SEND: begin
        timeoutCnt_d = '0;
        overrun_d    = byteEvent;
        state_d      = WAIT_TX;
      end

      WAIT_TX: begin
        timeoutCnt_d = '0;
        overrun_d    = byteEvent;
        if (bus.i_tx_done_tick) begin
          busy_d  = 1'b0;
          state_d = WAIT_A;
        end
      end

      default: begin
        timeoutCnt_d = '0;
        busy_d       = 1'b0;
        state_d      = WAIT_A;
      end
    endcase
  end

  assign bus.o_alu_a    = aluA_q;
  assign bus.o_alu_b    = aluB_q;
  assign bus.o_alu_op   = aluOp_q;
  assign bus.o_tx_data  = txData_q;
  assign bus.o_tx_start = txStart_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface. Frames are driven through the
// receiver-side signals; each frame's expected operands and result are queued
// and a monitor compares them whenever the block raises its transmit request.
module tb_uart_alu_interface;

  logic clk = 1'b0;
  logic rstN;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } frame_t;

  frame_t sbQ[$];
  frame_t monFrame;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opByte;
    logic [5:0] expOp;
    logic [7:0] res;
  } vec_t;

  // Hand-computed frames: SUB, AND, OR, XOR, SRA, SRL, NOR, masked AND
  vec_t vecs[8] = '{
    '{8'h10, 8'h20, 8'h22, 6'h22, 8'hF0},
    '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30},
    '{8'h01, 8'h02, 8'h25, 6'h25, 8'h03},
    '{8'hFF, 8'h0F, 8'h26, 6'h26, 8'hF0},
    '{8'h80, 8'h02, 8'h03, 6'h03, 8'hE0},
    '{8'h80, 8'h02, 8'h02, 6'h02, 8'h20},
    '{8'h0F, 8'h30, 8'h27, 6'h27, 8'hC0},
    '{8'hCC, 8'hAA, 8'hE4, 6'h24, 8'h88}
  };

  uart_alu_interface_if bus ();

  uart_alu_interface #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .NB_TIMEOUT     (20),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clock (clk),
    .i_reset (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational ALU
  function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return sa >>> b;
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign bus.i_alu_result = aluModel(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.i_rx_data      = b;
    bus.i_rx_done_tick = 1'b1;
    tick();
    bus.i_rx_done_tick = 1'b0;
    tick();
  endtask

  // skip=0 sends A,B,OP; skip=1 sends B,OP; skip=2 sends OP only
  task automatic applyStimulus(input int skip, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] opByte, input logic [5:0] expOp,
                               input logic [7:0] res, input bit injectOverrun);
    sbQ.push_back('{a: a, b: b, op: expOp, res: res});
    if (skip < 1) sendByte(a);
    if (skip < 2) sendByte(b);
    bus.i_rx_data      = opByte;
    bus.i_rx_done_tick = 1'b1;
    tick();
    bus.i_rx_done_tick = 1'b0;
    @(negedge clk);
    checkOutput("busy in EXEC", bus.o_busy, 1);
    checkOutput("no start in EXEC", bus.o_tx_start, 0);
    tick();
    @(negedge clk);
    checkOutput("start two cycles after OP", bus.o_tx_start, 1);
    tick();
    @(negedge clk);
    checkOutput("start lasts one cycle", bus.o_tx_start, 0);
    checkOutput("tx_data in WAIT_TX", bus.o_tx_data, res);
    if (injectOverrun) begin
      bus.i_rx_data      = 8'h99;
      bus.i_rx_done_tick = 1'b1;
      tick();
      bus.i_rx_done_tick = 1'b0;
      @(negedge clk);
      checkOutput("overrun pulse", bus.o_overrun, 1);
      checkOutput("tx_data kept on overrun", bus.o_tx_data, res);
      checkOutput("busy kept on overrun", bus.o_busy, 1);
      tick();
      @(negedge clk);
      checkOutput("overrun one cycle", bus.o_overrun, 0);
    end
    tick();
    tick();
    @(negedge clk);
    checkOutput("tx_data held until done", bus.o_tx_data, res);
    checkOutput("busy until done", bus.o_busy, 1);
    bus.i_tx_done_tick = 1'b1;
    tick();
    bus.i_tx_done_tick = 1'b0;
    @(negedge clk);
    checkOutput("busy cleared by done", bus.o_busy, 0);
    tick();
  endtask

  // Scoreboard monitor: every transmit request must match the oldest frame
  always @(negedge clk) begin
    if (rstN === 1'b1 && bus.o_tx_start === 1'b1) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected tx_start: got 0x1, expected 0x0");
      end else begin
        monFrame = sbQ.pop_front();
        checkOutput("frame tx_data", bus.o_tx_data, monFrame.res);
        checkOutput("frame alu_a", bus.o_alu_a, monFrame.a);
        checkOutput("frame alu_b", bus.o_alu_b, monFrame.b);
        checkOutput("frame alu_op", bus.o_alu_op, monFrame.op);
      end
    end
  end

  initial begin
    logic earlyTimeout;

    rstN               = 1'b0;
    bus.i_rx_done_tick = 1'b0;
    bus.i_rx_data      = 8'h00;
    bus.i_tx_done_tick = 1'b0;
    repeat (3) tick();

    @(negedge clk);
    checkOutput("reset alu_a", bus.o_alu_a, 0);
    checkOutput("reset alu_b", bus.o_alu_b, 0);
    checkOutput("reset alu_op", bus.o_alu_op, 0);
    checkOutput("reset tx_data", bus.o_tx_data, 0);
    checkOutput("reset tx_start", bus.o_tx_start, 0);
    checkOutput("reset busy", bus.o_busy, 0);
    checkOutput("reset timeout", bus.o_timeout, 0);
    checkOutput("reset overrun", bus.o_overrun, 0);
    tick();
    rstN = 1'b1;
    tick();

    // Reset in the middle of a frame
    sendByte(8'h05);
    @(negedge clk);
    checkOutput("A latched before reset", bus.o_alu_a, 8'h05);
    rstN = 1'b0;
    #1;
    checkOutput("async reset clears A", bus.o_alu_a, 0);
    checkOutput("async reset busy", bus.o_busy, 0);
    tick();
    rstN = 1'b1;
    tick();

    // First byte after reset must be operand A again
    applyStimulus(0, 8'h0F, 8'h03, 8'h20, 6'h20, 8'h12, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].opByte, vecs[i].expOp, vecs[i].res, 1'b0);
    end

    // Held-high receive tick counts as a single byte
    bus.i_rx_data      = 8'hAA;
    bus.i_rx_done_tick = 1'b1;
    repeat (40) tick();
    bus.i_rx_done_tick = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("held tick latches A", bus.o_alu_a, 8'hAA);
    checkOutput("held tick not busy", bus.o_busy, 0);
    applyStimulus(1, 8'hAA, 8'h01, 8'h20, 6'h20, 8'hAB, 1'b0);

    // Idle after A: abort on the 100th idle clock
    sendByte(8'h11);
    earlyTimeout = 1'b0;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      if (bus.o_timeout !== 1'b0) earlyTimeout = 1'b1;
      tick();
    end
    checkOutput("no early timeout", earlyTimeout, 0);
    @(negedge clk);
    checkOutput("timeout pulse", bus.o_timeout, 1);
    tick();
    @(negedge clk);
    checkOutput("timeout one cycle", bus.o_timeout, 0);
    checkOutput("A kept after timeout", bus.o_alu_a, 8'h11);
    checkOutput("B kept after timeout", bus.o_alu_b, 8'h01);

    // A byte on the last idle cycle beats the abort
    sendByte(8'h33);
    repeat (98) tick();
    bus.i_rx_data      = 8'h44;
    bus.i_rx_done_tick = 1'b1;
    tick();
    bus.i_rx_done_tick = 1'b0;
    @(negedge clk);
    checkOutput("late byte no timeout", bus.o_timeout, 0);
    tick();
    @(negedge clk);
    checkOutput("late byte no timeout next", bus.o_timeout, 0);
    checkOutput("late byte latched as B", bus.o_alu_b, 8'h44);
    applyStimulus(2, 8'h33, 8'h44, 8'h25, 6'h25, 8'h77, 1'b0);

    // Overrun during WAIT_TX, then a clean frame starting with A
    applyStimulus(0, 8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 1'b1);
    applyStimulus(0, 8'h05, 8'h06, 8'h20, 6'h20, 8'h0B, 1'b0);

    repeat (3) tick();
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Downstream consumer of the UART receiver. Assembles received bytes into an ALU command frame: operand A, operand B, opcode.
- Drives the combinational ALU with the registered operands and captures the result.
- Hands the result byte to the UART transmitter with a start/done handshake.
- Sits between rx_uart, the ALU and tx_uart in the TP2 top level.

Parameters:
NB_DATA, 8, width of UART bytes, operands and result
NB_OP, 6, opcode width; taken from the LSBs of the opcode byte, upper bits ignored
NB_STATE, 3, state register width
NB_TIMEOUT, 20, inter-byte timeout counter width
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one frame before abort

Ports:
i_clock  in  1  system clock (same clock as rx_uart/tx_uart)
i_reset  in  1  asynchronous, active-low reset
i_rx_done_tick  in  1  byte-valid from receiver; may be held high for more than one cycle
i_rx_data  in  NB_DATA  received byte, valid while i_rx_done_tick=1
i_alu_result  in  NB_DATA  combinational ALU output
i_tx_done_tick  in  1  transmitter finished current byte
o_alu_a  out  NB_DATA  registered operand A
o_alu_b  out  NB_DATA  registered operand B
o_alu_op  out  NB_OP  registered opcode
o_tx_data  out  NB_DATA  result byte to transmitter, held stable until i_tx_done_tick
o_tx_start  out  1  one-cycle transmit request
o_busy  out  1  high from opcode accept until i_tx_done_tick
o_timeout  out  1  one-cycle pulse when a partial frame is aborted
o_overrun  out  1  one-cycle pulse when a byte is dropped during EXEC/SEND/WAIT_TX

Behaviour:
- Reset (i_reset=0, async): state=WAIT_A; all outputs, counters and the edge-detect register are 0.
- Byte accept: a rising edge of i_rx_done_tick (current=1, registered previous=0) is one byte event. A held-high tick yields exactly one event.
- States:
  - WAIT_A: on a byte event, latch o_alu_a, clear the timeout counter, go to WAIT_B.
  - WAIT_B: on a byte event, latch o_alu_b, clear the counter, go to WAIT_OP.
  - WAIT_OP: on a byte event, latch o_alu_op=i_rx_data[NB_OP-1:0], go to EXEC; o_busy=1 from the next cycle.
  - EXEC (1 cycle): o_alu_* are stable; at the end of the cycle, o_tx_data<=i_alu_result; go to SEND.
  - SEND (1 cycle): o_tx_start=1; go to WAIT_TX.
  - WAIT_TX: on i_tx_done_tick=1, clear o_busy and go to WAIT_A. o_tx_data holds throughout.
- Timeout:
  - In WAIT_B/WAIT_OP the counter increments each clock without a byte event.
  - When it reaches TIMEOUT_CYCLES-1: pulse o_timeout, go to WAIT_A, keep operand registers unchanged.
  - A byte event in that same cycle has priority: the byte is accepted and there is no timeout.
  - The counter saturates; it never wraps.
- Overrun: a byte event in EXEC/SEND/WAIT_TX is discarded and o_overrun pulses. State is unaffected.
- Latency: OP byte event at cycle N → EXEC at N+1 → o_tx_start high at N+2 only.
- i_tx_done_tick outside WAIT_TX is ignored.
- Undefined state encodings go to WAIT_A.

Decomposition:
- Shared package/header `uart_pkg`:
  - state encodings WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SEND=4, WAIT_TX=5
  - NB_DATA and NB_OP defaults
  - opcode constants (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR), shared with the ALU
- Sub-module `edge_pulse`: rising-edge detector for i_rx_done_tick, with async active-low reset. Everything else stays in one FSM module.

Test Plan:
- Reset mid-frame: after A=0x05 is accepted, drop i_reset → state WAIT_A, all outputs 0 immediately; the next byte is treated as A.
- Frame A=0x0F, B=0x03, OP=0x20 (ADD), ALU model returns 0x12:
  - o_alu_a=0x0F, o_alu_b=0x03, o_alu_op=0x20 in EXEC
  - o_tx_start high exactly 1 cycle, 2 cycles after the OP event
  - o_tx_data=0x12 until i_tx_done_tick; o_busy clears on it
- Held tick: i_rx_done_tick high 40 cycles with 0xAA → only A=0xAA is latched; state WAIT_B, not WAIT_OP.
- Timeout (TIMEOUT_CYCLES=100): send A only, then idle → o_timeout pulses once at the 100th idle clock; a byte 1 cycle earlier is accepted instead.
- Overrun: a byte event during WAIT_TX → o_overrun 1-cycle pulse; o_tx_data unchanged; after i_tx_done_tick the next byte becomes A.
- Opcode masking: OP byte 0xE4 → o_alu_op=6'h24.
